// File: rtl/load_store_fsm_if.sv
// Control bundle between the instruction-fetch/memory side (master) and the
// LOAD/STORE sequencer (slave).
interface load_store_fsm_if;
    logic [3:0] FSM_start;
    logic [5:0] param1;
    logic [5:0] param2;
    logic       MFC;
    logic [5:0] register_addr;
    logic       bus_register_input_en;
    logic       bus_register_out_en;
    logic       MAR_address_in_en;
    logic       MDR_bus_data_in_en;
    logic       MDR_bus_data_out_en;
    logic       EN;
    logic       R_W;
    logic       done;
    logic       busy;
    logic       mem_error;

    modport master (
        output FSM_start, param1, param2, MFC,
        input  register_addr, bus_register_input_en, bus_register_out_en,
               MAR_address_in_en, MDR_bus_data_in_en, MDR_bus_data_out_en,
               EN, R_W, done, busy, mem_error
    );

    modport slave (
        input  FSM_start, param1, param2, MFC,
        output register_addr, bus_register_input_en, bus_register_out_en,
               MAR_address_in_en, MDR_bus_data_in_en, MDR_bus_data_out_en,
               EN, R_W, done, busy, mem_error
    );
endinterface

// File: rtl/load_store_fsm.sv
// LOAD/STORE memory-access sequencer: drives bus, register file, MAR/MDR and
// the EN/R_W/MFC handshake, with a bounded wait for MFC.
module load_store_fsm #(
    parameter logic [3:0] LOAD_CODE   = 4'd5,
    parameter logic [3:0] STORE_CODE  = 4'd6,
    parameter int         MFC_TIMEOUT = 16
) (
    input logic             clock,
    input logic             reset,
    load_store_fsm_if.slave bus
);
    localparam int CNT_W = $clog2(MFC_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MFC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_MEM, S_WB, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             is_store_q, is_store_d;
    logic [5:0]       p1_q, p1_d;
    logic [5:0]       p2_q, p2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_error_q, mem_error_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            is_store_q  <= 1'b0;
            p1_q        <= '0;
            p2_q        <= '0;
            cnt_q       <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            cnt_q       <= cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        cnt_d       = cnt_q;
        mem_error_d = mem_error_q;
        case (state_q)
            S_IDLE: begin
                if (bus.FSM_start == LOAD_CODE || bus.FSM_start == STORE_CODE) begin
                    state_d     = S_ADDR;
                    is_store_d  = (bus.FSM_start == STORE_CODE);
                    p1_d        = bus.param1;
                    p2_d        = bus.param2;
                    mem_error_d = 1'b0;
                end
            end
            S_ADDR: begin
                state_d = is_store_q ? S_DATA : S_MEM;
                cnt_d   = '0;
            end
            S_DATA: begin
                state_d = S_MEM;
                cnt_d   = '0;
            end
            S_MEM: begin
                // MFC wins over a timeout landing on the same edge.
                if (bus.MFC) begin
                    state_d = is_store_q ? S_DONE : S_WB;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    mem_error_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode; everything idles at 0 so the top level can OR FSMs.
    always_comb begin
        bus.register_addr         = '0;
        bus.bus_register_input_en = 1'b0;
        bus.bus_register_out_en   = 1'b0;
        bus.MAR_address_in_en     = 1'b0;
        bus.MDR_bus_data_in_en    = 1'b0;
        bus.MDR_bus_data_out_en   = 1'b0;
        bus.EN                    = 1'b0;
        bus.R_W                   = 1'b0;
        bus.done                  = 1'b0;
        bus.busy                  = (state_q != S_IDLE);
        case (state_q)
            S_ADDR: begin
                bus.register_addr       = p2_q;
                bus.bus_register_out_en = 1'b1;
                bus.MAR_address_in_en   = 1'b1;
            end
            S_DATA: begin
                bus.register_addr       = p1_q;
                bus.bus_register_out_en = 1'b1;
                bus.MDR_bus_data_in_en  = 1'b1;
            end
            S_MEM: begin
                bus.EN  = 1'b1;
                bus.R_W = !is_store_q;
            end
            S_WB: begin
                bus.register_addr         = p1_q;
                bus.MDR_bus_data_out_en   = 1'b1;
                bus.bus_register_input_en = 1'b1;
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.mem_error = mem_error_q;
endmodule
